tff_toggle_arbiter: RTL and testbench
=====================================

// Module: tff_toggle_arbiter
// PURPOSE
//  Shares one bank of T flip-flops between NUM_REQ requesters.
//  Each requester asks for a burst of CNT toggles on one selected bit.
//  Bursts are granted round-robin, and the granted burst drives exactly one toggle per clock.
//  Sits between the ui_in/uio_in request pins and the uo_out state pins of the T-flip-flop project.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  WIDTH    4  number of T flip-flops in the shared bank (1..8)
//  CNT_W    4  width of each burst-length field
//  IDX_W    $clog2(WIDTH) (min 1)  localparam; width of each bit-select field
// PORTS
//  clk      in   1              clock; all state updates on rising edge
//  rst_n    in   1              synchronous reset, active low
//  req      in   NUM_REQ        per-requester level request; held until ack
//  sel      in   NUM_REQ*IDX_W  per-requester target bit; slice i = sel[i*IDX_W +: IDX_W]
//  cnt      in   NUM_REQ*CNT_W  per-requester burst length, slice i as for sel
//  pause    in   1              stalls an active burst (no toggle, no count)
//  ack      out  NUM_REQ        one-cycle completion pulse to the granted requester
//  busy     out  1              high while state != IDLE
//  grant_id out  $clog2(NUM_REQ) index of current or last granted requester
//  q        out  WIDTH          T flip-flop bank state
// BEHAVIOUR
//  Reset (rst_n low at a clock edge): the following take effect at that edge.
//   - state=IDLE, rr_ptr=0, q=0, ack=0, busy=0, grant_id=0, remaining=0.
//   - Reset mid-burst aborts the burst. No ack is issued.
//  States: IDLE -> BURST -> DONE -> IDLE, all registered.
//  IDLE:
//   - If req!=0, grant the first set req bit searching from rr_ptr upward (mod NUM_REQ).
//   - Latch that requester's sel and cnt. Set grant_id. Go to BURST with remaining=cnt.
//   - If the latched cnt==0, go straight to DONE. No toggle occurs.
//  BURST, per cycle:
//   - pause=1: hold; no toggle, remaining unchanged.
//   - pause=0: q[sel_l] <= ~q[sel_l]; remaining <= remaining-1.
//   - The toggle that brings remaining to 0 also moves state to DONE.
//  DONE (one cycle):
//   - ack[grant_id]=1; all other ack bits are 0.
//   - rr_ptr <= grant_id+1, wrapping NUM_REQ-1 -> 0. Next state IDLE.
//  Timing: req sampled at edge E0.
//   - Toggles occur at E1..Ecnt when there is no pause.
//   - ack is high between Ecnt and Ecnt+1.
//   - The earliest next grant is at Ecnt+2.
//   - Throughput is cnt+2 cycles per burst.
//  Requester rule: drop req on the edge after ack is seen. A req still high in the following IDLE cycle counts as a new request.
//  req dropped or sel/cnt changed mid-burst: ignored. The latched burst completes and ack still pulses.
//  Latched sel >= WIDTH: the burst runs its full length with no toggles, then ack.
//  q bits not selected by the active burst hold their value. Only one bit of q changes per cycle.
//  busy = (state!=IDLE), registered with the state. ack is never asserted outside DONE.
// STRUCTURE
//  Package tff_arb_pkg:
//   - state enum {IDLE, BURST, DONE} (2-bit)
//   - defaults NUM_REQ/WIDTH/CNT_W
//  Sub-module tff_bank:
//   - WIDTH T flip-flops with sync active-low reset
//   - ports clk, rst_n, tog_en, tog_idx, q
//   - toggles q[tog_idx] when tog_en and tog_idx<WIDTH
//  Top-level holds the FSM, the round-robin pointer and the burst counter.
// TESTING
//  1. Reset: run a burst, assert rst_n=0 for one edge mid-BURST -> q=0, busy=0, ack=0, no later ack.
//  2. Single requester: req[0], sel0=2, cnt0=3 -> q[2] toggles at E1,E2,E3, ends at 1; ack[0] high after E3 only.
//  3. Round-robin: req=4'b1111 held, cnt=1 each -> grant order 0,1,2,3,0; each ack 3 cycles apart.
//  4. Pause: cnt=4 with pause high for 2 cycles mid-burst -> exactly 4 toggles; ack delayed by 2 cycles.
//  5. Edge cases:
//     - cnt=0 -> no toggle, ack 1 cycle after grant.
//     - cnt=15 -> 15 toggles, q bit ends inverted.
//     - sel>=WIDTH (WIDTH=3) -> no q change, ack still issued.
//  6. Mid-burst interference: req drops and sel changes during BURST -> original bit toggled cnt times, ack issued.

Source files
------------

// File: rtl/tff_arb_pkg.sv
// Shared types and defaults for the T flip-flop toggle arbiter.
package tff_arb_pkg;

    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefWidth  = 4;
    localparam int unsigned DefCntW   = 4;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_e;

    // Width of a bit-select field; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops; at most one bit toggles per clock.
module tff_bank #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_en,
    input  logic [IDX_W-1:0] tog_idx,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] tog_mask;

    // Decode the toggle index; an index >= WIDTH matches no bit
    always_comb begin
        tog_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog_mask[i] = tog_en && (tog_idx == IDX_W'(i));
        end
    end

    // Flip-flop state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q ^ tog_mask;
        end
    end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting toggle bursts on a shared T flip-flop bank.
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DefNumReq,
    parameter  int unsigned WIDTH   = DefWidth,
    parameter  int unsigned CNT_W   = DefCntW,
    localparam int unsigned IDX_W   = idx_width(WIDTH),
    localparam int unsigned GID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] sel,
    input  logic [NUM_REQ*CNT_W-1:0] cnt,
    input  logic                     pause,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     busy,
    output logic [GID_W-1:0]         grant_id,
    output logic [WIDTH-1:0]         q
);

    localparam logic [1:0] StIdle  = ARB_IDLE;
    localparam logic [1:0] StBurst = ARB_BURST;
    localparam logic [1:0] StDone  = ARB_DONE;

    logic [1:0]       state_q, state_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [IDX_W-1:0] sel_l_q, sel_l_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [IDX_W-1:0] sel_arr [NUM_REQ];
    logic [CNT_W-1:0] cnt_arr [NUM_REQ];

    logic             found;
    logic [GID_W-1:0] pick;
    logic             tog_en;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign sel_arr[g] = sel[g*IDX_W +: IDX_W];
        assign cnt_arr[g] = cnt[g*CNT_W +: CNT_W];
    end

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned cand;
        logic [GID_W-1:0] cidx;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        cidx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_REQ;
            cidx = GID_W'(cand);
            if (!found && req[cidx]) begin
                found = 1'b1;
                pick  = cidx;
            end
        end
    end

    // FSM, round-robin pointer and burst counter next-state
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        sel_l_d     = sel_l_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_id_d  = pick;
                    sel_l_d     = sel_arr[pick];
                    remaining_d = cnt_arr[pick];
                    // Zero-length bursts skip straight to completion
                    state_d     = (cnt_arr[pick] == '0) ? StDone : StBurst;
                end
            end
            StBurst: begin
                if (!pause) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                rr_ptr_d = (32'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            sel_l_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            sel_l_q     <= sel_l_d;
            remaining_q <= remaining_d;
        end
    end

    // Outputs decoded directly from registered state
    always_comb begin
        tog_en   = (state_q == StBurst) && !pause;
        busy     = (state_q != StIdle);
        grant_id = grant_id_q;
        ack      = (state_q == StDone) ? (NUM_REQ'(1) << grant_id_q) : '0;
    end

    tff_bank #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .tog_en  (tog_en),
        .tog_idx (sel_l_q),
        .q       (q)
    );

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Self-checking bench for tff_toggle_arbiter (WIDTH=3 so sel=3 is out of range).
module tb_tff_toggle_arbiter;

    localparam int NR = 4;
    localparam int W  = 3;
    localparam int CW = 4;
    localparam int IW = 2;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*IW-1:0] sel = '0;
    logic [NR*CW-1:0] cnt = '0;
    logic             pause = 1'b0;
    logic [NR-1:0]    ack;
    logic             busy;
    logic [GW-1:0]    grant_id;
    logic [W-1:0]     q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int t0 = 0;
    bit chk_en = 1'b0;

    tff_toggle_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .sel      (sel),
        .cnt      (cnt),
        .pause    (pause),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .q        (q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a burst is (owner, bit, length); it is served one
    // toggle per unpaused cycle, then one completion cycle, then an idle cycle.
    int         m_phase = 0;   // 0 waiting, 1 serving, 2 completing
    int         m_left  = 0;
    int         m_gid   = 0;
    int         m_next  = 0;
    int         m_bit   = 0;
    logic [W-1:0] m_q   = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_gid = 0; m_next = 0; m_bit = 0; m_q = '0;
        end else if (m_phase == 0) begin
            for (int k = 0; k < NR; k++) begin
                int id;
                id = (m_next + k) % NR;
                if (m_phase == 0 && req[id]) begin
                    m_gid   = id;
                    m_bit   = int'(sel[id*IW +: IW]);
                    m_left  = int'(cnt[id*CW +: CW]);
                    m_phase = (m_left == 0) ? 2 : 1;
                end
            end
        end else if (m_phase == 1) begin
            if (!pause) begin
                if (m_bit < W) m_q[m_bit] = ~m_q[m_bit];
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            m_next  = (m_gid + 1) % NR;
            m_phase = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (ack != '0) ack_cnt++;
        if (chk_en) begin
            check("q", 32'(q), 32'(m_q));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("ack", 32'(ack), (m_phase == 2) ? (32'd1 << m_gid) : 32'd0);
            check("grant_id", 32'(grant_id), 32'(m_gid));
        end
    end

    task automatic issue(input int id, input int s, input int c);
        sel[id*IW +: IW] = IW'(s);
        cnt[id*CW +: CW] = CW'(c);
        req[id] = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_ack(input int id, input int budget, output int delta);
        bit seen;
        seen = 1'b0;
        delta = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ack[id]) begin
                seen = 1'b1;
                delta = cyc - t0;
                req[id] = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack[%0d] expected one within %0d cycles", id, budget);
        end
        @(negedge clk);
    endtask

    task automatic wait_any_ack(input int budget, output int id, output int at);
        bit seen;
        seen = 1'b0;
        id = -1;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                seen = 1'b1;
                at = cyc;
                for (int b = 0; b < NR; b++) if (ack[b]) id = b;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout: got no ack expected one within %0d cycles", budget);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        pause = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int d;
    int acks_before;
    int rr_id [5];
    int rr_at [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_q", 32'(q), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_gid", 32'(grant_id), 32'd0);
        rst_n = 1'b1;

        // 1. reset mid-burst aborts without ack
        @(negedge clk);
        issue(0, 1, 8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_q", 32'(q), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        acks_before = ack_cnt;
        repeat (12) @(negedge clk);
        check("abort_no_ack", 32'(ack_cnt - acks_before), 32'd0);

        // 2. single requester, bit 2, three toggles
        issue(0, 2, 3);
        wait_ack(0, 40, d);
        check("single_latency", 32'(d), 32'd4);
        check("single_q", 32'(q), 32'b100);

        // 3. round-robin from a fresh pointer, all requests held
        pulse_reset();
        @(negedge clk);
        sel = {2'd0, 2'd2, 2'd1, 2'd0};
        cnt = 16'h1111;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_any_ack(40, rr_id[i], rr_at[i]);
        end
        req = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 32'(rr_id[i]), 32'(exp_order[i]));
            if (i > 0) check("rr_spacing", 32'(rr_at[i] - rr_at[i-1]), 32'd3);
        end
        check("rr_q", 32'(q), 32'b111);

        // 4. pause stretches the burst by two cycles without extra toggles
        issue(1, 1, 4);
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (2) @(negedge clk);
        pause = 1'b0;
        wait_ack(1, 40, d);
        check("pause_latency", 32'(d), 32'd7);
        check("pause_q", 32'(q), 32'b111);

        // 5a. zero-length burst
        issue(2, 0, 0);
        wait_ack(2, 40, d);
        check("cnt0_latency", 32'(d), 32'd1);
        check("cnt0_q", 32'(q), 32'b111);

        // 5b. maximum-length burst inverts the bit
        issue(3, 2, 15);
        wait_ack(3, 60, d);
        check("cnt15_latency", 32'(d), 32'd16);
        check("cnt15_q", 32'(q), 32'b011);

        // 5c. out-of-range bit select
        issue(0, 3, 2);
        wait_ack(0, 40, d);
        check("oor_latency", 32'(d), 32'd3);
        check("oor_q", 32'(q), 32'b011);

        // 6. request dropped and fields changed mid-burst
        issue(1, 0, 5);
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        sel[1*IW +: IW] = 2'd2;
        cnt[1*CW +: CW] = 4'd9;
        wait_ack(1, 40, d);
        check("interf_latency", 32'(d), 32'd6);
        check("interf_q", 32'(q), 32'b010);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
